// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, frame constants and loader state encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 16;

    localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : framed byte-stream program loader with XOR checksum check
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int                 MEM_DEPTH = 16,
    parameter int                 ADDR_W    = 4,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   loaded_len
);

    import cpu_pkg::*;

    loader_state_t      r_state;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W-1:0]  r_idx;
    logic [DATA_W-1:0]  r_csum;

    logic               w_accept;
    logic               w_is_sync;
    logic               w_len_bad;
    logic               w_last;

    assign w_accept  = in_valid && in_ready;
    assign w_is_sync = (in_data == SYNC_BYTE);
    assign w_len_bad = (in_data == '0) || (in_data > DATA_W'(MEM_DEPTH));
    // Address counter stops at LEN-1; that byte closes the payload.
    assign w_last    = (({1'b0, r_idx} + (ADDR_W+1)'(1)) == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_run    <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            loaded_len <= '0;
        end else begin
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_sync) begin
                            r_state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (w_len_bad) begin
                            r_state  <= ST_ERR;
                            load_err <= 1'b1;
                        end else begin
                            r_len   <= in_data[ADDR_W:0];
                            r_idx   <= '0;
                            r_csum  <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_idx;
                        mem_wdata <= in_data;
                        r_csum    <= r_csum ^ in_data;
                        if (w_last) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_idx <= r_idx + ADDR_W'(1);
                        end
                    end
                    ST_CSUM: begin
                        if (in_data == r_csum) begin
                            r_state    <= ST_RUN;
                            cpu_run    <= 1'b1;
                            load_done  <= 1'b1;
                            loaded_len <= r_len;
                            load_err   <= 1'b0;
                        end else begin
                            r_state  <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // A new header takes the memory back from the CPU.
                        if (w_is_sync) begin
                            cpu_run <= 1'b0;
                            r_state <= ST_LEN;
                        end
                    end
                    ST_ERR: begin
                        if (w_is_sync) begin
                            r_state <= ST_LEN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule : prog_loader

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : randomized frames against a byte-stream reference model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

    localparam int         DEPTH = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, mem_we, cpu_run, load_done, load_err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [4:0] loaded_len;

    always #5 clk = ~clk;

    prog_loader #(
        .MEM_DEPTH (16),
        .ADDR_W    (4),
        .DATA_W    (8),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err),
        .loaded_len (loaded_len)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bytes since the last header are kept in a queue and
    // the frame is judged from its contents as each byte arrives.
    bit         m_ready, m_we, m_done, m_run, m_err;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;
    logic [4:0] m_len;
    bit         in_frame;
    logic [7:0] frame[$];

    logic [7:0] shadow[16];
    int         n_writes = 0;
    int         n_done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_we = 0; m_done = 0; m_run = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_len = '0;
        in_frame = 0;
        frame.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n, len;
        logic [7:0] x;
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame = 1;
                frame.delete();
                m_run = 0;
            end
        end else begin
            frame.push_back(b);
            n   = frame.size();
            len = int'(frame[0]);
            if (n == 1) begin
                if (len == 0 || len > DEPTH) begin
                    in_frame = 0;
                    m_err    = 1;
                end
            end else if (n <= len + 1) begin
                m_we    = 1;
                m_addr  = 4'(n - 2);
                m_wdata = b;
            end else begin
                x = 8'h00;
                for (int i = 1; i <= len; i++) x = x ^ frame[i];
                if (x == b) begin
                    m_run  = 1;
                    m_done = 1;
                    m_len  = 5'(len);
                    m_err  = 0;
                end else begin
                    m_err = 1;
                end
                in_frame = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                m_we   = 0;
                m_done = 0;
                if (in_valid && m_ready) model_byte(in_data);
                m_ready = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready",   32'(in_ready),   32'(m_ready));
            chk("mem_we",     32'(mem_we),     32'(m_we));
            if (m_we) begin
                chk("mem_addr",  32'(mem_addr),  32'(m_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            if (rst) begin
                chk("rst_addr",  32'(mem_addr),  32'h0);
                chk("rst_wdata", 32'(mem_wdata), 32'h0);
            end
            chk("load_done",  32'(load_done),  32'(m_done));
            chk("cpu_run",    32'(cpu_run),    32'(m_run));
            chk("load_err",   32'(load_err),   32'(m_err));
            chk("loaded_len", 32'(loaded_len), 32'(m_len));
            if (mem_we === 1'b1) begin
                shadow[mem_addr] = mem_wdata;
                n_writes++;
            end
            if (load_done === 1'b1) n_done++;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic send_frame(input int len, input bit corrupt, input int maxgap);
        logic [7:0] x, d;
        x = 8'h00;
        send(SYNC, $urandom_range(maxgap, 0));
        send(8'(len), $urandom_range(maxgap, 0));
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            x = x ^ d;
            send(d, $urandom_range(maxgap, 0));
        end
        if (corrupt) x = x ^ 8'($urandom_range(255, 1));
        send(x, $urandom_range(maxgap, 0));
    endtask

    initial begin
        int w0, d0;
        logic [7:0] x;
        logic [7:0] data[16];

        idle(3);
        chk("reset_ready", 32'(in_ready), 32'h0);
        chk("reset_len",   32'(loaded_len), 32'h0);
        rst = 1'b0;
        idle(3);

        // Good 3-byte frame
        w0 = n_writes; d0 = n_done;
        send(8'hA5, 0); send(8'h03, 0); send(8'h08, 0);
        send(8'h18, 0); send(8'h28, 0); send(8'h38, 0);
        chk("f1_run", 32'(cpu_run), 32'h1);
        idle(2);
        chk("f1_m0", 32'(shadow[0]), 32'h08);
        chk("f1_m1", 32'(shadow[1]), 32'h18);
        chk("f1_m2", 32'(shadow[2]), 32'h28);
        chk("f1_writes", 32'(n_writes - w0), 32'd3);
        chk("f1_done",   32'(n_done - d0), 32'd1);
        chk("f1_len",    32'(loaded_len), 32'd3);

        // Bad checksum reload from RUN
        w0 = n_writes;
        send(8'hA5, 0); send(8'h02, 0); send(8'h08, 0);
        send(8'h18, 0); send(8'h00, 1);
        chk("f2_writes", 32'(n_writes - w0), 32'd2);
        chk("f2_err", 32'(load_err), 32'h1);
        chk("f2_run", 32'(cpu_run), 32'h0);
        chk("f2_len", 32'(loaded_len), 32'd3);

        // Leading junk, payload equal to the header byte
        send(8'h00, 0); send(8'hFF, 0); send(8'hA5, 0);
        send(8'h01, 0); send(8'hA5, 0); send(8'hA5, 1);
        chk("f3_m0",  32'(shadow[0]), 32'hA5);
        chk("f3_run", 32'(cpu_run), 32'h1);
        chk("f3_err", 32'(load_err), 32'h0);
        chk("f3_len", 32'(loaded_len), 32'd1);

        // Length limits
        w0 = n_writes;
        send(8'hA5, 0); send(8'h00, 1);
        send(8'hA5, 0); send(8'h11, 1);
        chk("len_writes", 32'(n_writes - w0), 32'd0);
        chk("len_err", 32'(load_err), 32'h1);
        chk("len_keep", 32'(loaded_len), 32'd1);
        w0 = n_writes;
        x = 8'h00;
        send(8'hA5, 0); send(8'h10, 0);
        for (int i = 0; i < 16; i++) begin
            data[i] = 8'($urandom);
            x = x ^ data[i];
            send(data[i], 0);
        end
        send(x, 2);
        chk("full_writes", 32'(n_writes - w0), 32'd16);
        for (int i = 0; i < 16; i++) chk("full_mem", 32'(shadow[i]), 32'(data[i]));
        chk("full_len", 32'(loaded_len), 32'd16);

        // Reload while running
        send(8'hA5, 0);
        chk("rl_drop", 32'(cpu_run), 32'h0);
        send(8'h01, 0); send(8'h88, 0); send(8'h88, 1);
        chk("rl_m0",  32'(shadow[0]), 32'h88);
        chk("rl_run", 32'(cpu_run), 32'h1);

        // Reset mid-frame, then gapped reload
        send(8'hA5, 1); send(8'h05, 0); send(8'h11, 2);
        send(8'h22, 0); send(8'h33, 0);
        rst = 1'b1;
        #1;
        chk("mr_ready", 32'(in_ready), 32'h0);
        chk("mr_we",    32'(mem_we), 32'h0);
        chk("mr_run",   32'(cpu_run), 32'h0);
        chk("mr_len",   32'(loaded_len), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);
        w0 = n_writes;
        send_frame(5, 0, 3);
        idle(1);
        chk("mr2_writes", 32'(n_writes - w0), 32'd5);
        chk("mr2_len", 32'(loaded_len), 32'd5);
        chk("mr2_run", 32'(cpu_run), 32'h1);

        // Randomized traffic
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(9, 0))
                0, 1, 2, 3: send_frame($urandom_range(16, 1), 0, $urandom_range(2, 0));
                4, 5:       send_frame($urandom_range(16, 1), 1, $urandom_range(2, 0));
                6: begin
                    send(SYNC, $urandom_range(1, 0));
                    send(($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 17)), 0);
                end
                7, 8:       send(8'($urandom), $urandom_range(3, 0));
                default:    pulse_reset();
            endcase
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prog_loader

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Upstream stage of the accumulator CPU: receives a program as a framed byte stream over a valid/ready handshake, writes it into the CPU's 16 x 8-bit instruction/data memory, and checks an XOR checksum. On a good frame it asserts `cpu_run` to release the CPU from its fetch hold; on a bad frame it flags `load_err` and keeps the CPU held. It owns the memory write port while the CPU is halted.

## Interface
- `MEM_DEPTH`, 16, number of memory words; must equal 2**`ADDR_W`
- `ADDR_W`, 4, memory address width
- `DATA_W`, 8, byte/word width
- `SYNC_BYTE`, 8'hA5, frame header value

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream byte valid
- `in_data`  in  `DATA_W`  upstream byte
- `in_ready`  out  1  loader can accept a byte; transfer when `in_valid && in_ready` at a rising edge
- `mem_we`  out  1  one-cycle memory write strobe
- `mem_addr`  out  `ADDR_W`  memory write address
- `mem_wdata`  out  `DATA_W`  memory write data
- `cpu_run`  out  1  level; CPU may execute while high
- `load_done`  out  1  one-cycle pulse on good checksum
- `load_err`  out  1  level; last frame rejected
- `loaded_len`  out  `ADDR_W`+1  word count of last accepted frame

## Operation
- Frame: `SYNC_BYTE`, LEN (1..`MEM_DEPTH`), LEN data bytes, CSUM = XOR of the data bytes (seed 8'h00).
- States: IDLE, LEN, DATA, CSUM, RUN, ERR.
- IDLE: accepted byte == `SYNC_BYTE` -> LEN; any other byte discarded, stay.
- LEN: LEN == 0 or LEN > `MEM_DEPTH` -> ERR; else latch count, clear address counter and checksum -> DATA.
- DATA: each accepted byte written to `mem_addr` = index (0..LEN-1), folded into checksum; after byte LEN-1 -> CSUM. Address counter never wraps; it stops at LEN-1.
- CSUM: byte == running XOR -> RUN, pulse `load_done`, `loaded_len` = LEN, clear `load_err`; mismatch -> ERR, set `load_err`, `loaded_len` unchanged.
- RUN: `cpu_run` = 1. Accepted `SYNC_BYTE` -> deassert `cpu_run`, -> LEN (reload). Other bytes discarded.
- ERR: `load_err` = 1, `cpu_run` = 0. Accepted `SYNC_BYTE` -> LEN; `load_err` stays set until next good CSUM.
- Words written before an error remain in memory; no rollback.
- `in_ready` = 1 in every state after reset release; no internal backpressure.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `load_done`=0, `load_err`=0, `loaded_len`=0; state IDLE.
- `in_ready` rises on the first clock edge after `rst` deasserts.
- All outputs registered. Data byte accepted at edge N -> `mem_we`/`mem_addr`/`mem_wdata` valid during cycle N..N+1 (one-cycle latency), one write per accepted byte; back-to-back bytes give back-to-back writes.
- CSUM accepted at edge N -> `cpu_run`, `load_done`, `loaded_len` (or `load_err`) updated at edge N.
- `SYNC_BYTE` in RUN accepted at edge N -> `cpu_run` low from edge N; no memory write occurs while `cpu_run` is high.
- Data byte equal to `SYNC_BYTE` inside DATA/CSUM is payload, not a resync.
- `in_valid` low: no state change, `mem_we` low.
- `rst` asserted mid-frame: immediate return to reset values and IDLE; partial frame abandoned.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`, `DATA_W`, `MEM_DEPTH`, `SYNC_BYTE`, and the loader state enum `loader_state_t`; same widths used by the CPU memory.
- Single module; no sub-module needed. Memory array stays in the CPU; loader drives only its write port.

## Test plan
- Reset then frame A5,03,08,18,28,38 -> writes M[0]=08, M[1]=18, M[2]=28 on consecutive cycles, `load_done` pulse, `cpu_run`=1, `loaded_len`=3.
- Frame A5,02,08,18,00 (bad CSUM, expected 10) -> two writes, `load_err`=1, `cpu_run`=0, `loaded_len` unchanged.
- Bytes 00,FF,A5,01,A5,A5 -> leading 00/FF ignored, M[0]=A5, CSUM A5 accepted, `cpu_run`=1.
- Length edge cases: A5,00 and A5,11 -> ERR with zero writes; A5,10 + 16 bytes + XOR -> writes M[0]..M[15], no wrap, `loaded_len`=16.
- In RUN, send A5,01,88,88 -> `cpu_run` drops at A5 acceptance, M[0]=88, `cpu_run` re-asserts.
- `rst` pulsed after third data byte of a 5-byte frame -> all outputs to reset values, next full frame loads normally; `in_valid` gaps mid-frame produce no spurious writes.
